// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ one-entry request slots.
// Define RF_ARB_X0_DROP_EN to handshake writes to address 0 but never queue or issue them.
module rf_wport_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic                          rf_wen,
   output logic [ADDR_WIDTH-1:0]         rf_waddr,
   output logic [DATA_WIDTH-1:0]         rf_wdata,
   input  logic [ADDR_WIDTH-1:0]         chk_addr,
   output logic                          chk_hit,
   output logic                          idle
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    slot_valid_q, slot_valid_d;
   logic [ADDR_WIDTH-1:0] slot_addr_q [NUM_REQ];
   logic [ADDR_WIDTH-1:0] slot_addr_d [NUM_REQ];
   logic [DATA_WIDTH-1:0] slot_data_q [NUM_REQ];
   logic [DATA_WIDTH-1:0] slot_data_d [NUM_REQ];
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

   logic                  gnt_any, hi_any;
   logic [PTR_W-1:0]      gnt_idx, hi_idx, lo_idx;
   logic [NUM_REQ-1:0]    gnt;

   // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index overall.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt_any = 1'b0;
      hi_any  = 1'b0;
      hi_idx  = '0;
      lo_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (slot_valid_q[i]) begin
            gnt_any = 1'b1;
            lo_idx  = PTR_W'(i);
         end
         if (slot_valid_q[i] && (PTR_W'(i) >= rr_ptr_q)) begin
            hi_any = 1'b1;
            hi_idx = PTR_W'(i);
         end
      end
      gnt_idx = hi_any ? hi_idx : lo_idx;
      gnt     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt[i] = gnt_any && (gnt_idx == PTR_W'(i));
      end
   end

   always_comb begin
      rf_wen    = !reset && gnt_any;
      rf_waddr  = rf_wen ? slot_addr_q[gnt_idx] : '0;
      rf_wdata  = rf_wen ? slot_data_q[gnt_idx] : '0;
      idle      = reset || !(|slot_valid_q);
      chk_hit   = 1'b0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = !reset && (!slot_valid_q[i] || gnt[i]);
         if (!reset && slot_valid_q[i] && (slot_addr_q[i] == chk_addr)) begin
            chk_hit = 1'b1;
         end
      end
   end

   // Drain first, then accept: a slot refilled in its own drain cycle stays valid with the new entry.
   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_addr_d  = slot_addr_q;
      slot_data_d  = slot_data_q;
      rr_ptr_d     = rr_ptr_q;
      if (rf_wen) begin
         slot_valid_d[gnt_idx] = 1'b0;
         rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            slot_addr_d[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            slot_data_d[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef RF_ARB_X0_DROP_EN
            slot_valid_d[i] = (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0);
`else
            slot_valid_d[i] = 1'b1;
`endif
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid_q <= '0;
         rr_ptr_q     <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   // NOTE: payload storage has no reset; it is only ever observed behind slot_valid.
   always_ff @(posedge clk) begin
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
   end

endmodule
